float_conv_sched: RTL
=====================

// Module: float_conv_sched
// PURPOSE
//  Round-robin scheduler sharing one 12-bit two's-complement -> S/E/F float converter among NREQ requesters.
//  Accepts one sample per grant, registers operand and result, and returns the result tagged with the requester ID.
//  Holds the result until the consumer accepts it.
//  Sits between the lab switch/sample sources and the display/formatting logic.
// PARAMETERS
//  NREQ  2  number of requesters (2..8)
//  IDW   1  requester ID width, = clog2(NREQ) (min 1)
// PORTS
//  clk        in   1          system clock; all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NREQ       per-requester sample valid
//  req_data   in   12*NREQ    per-requester 12-bit two's-complement sample; slice i = [12*i+11:12*i]
//  req_ready  out  NREQ       one-hot accept strobe; a sample is taken when req_valid[i] & req_ready[i]
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts the result when out_valid & out_ready
//  out_id     out  IDW        requester that owns the result
//  out_s      out  1          sign bit
//  out_e      out  3          exponent
//  out_f      out  4          mantissa
//  busy       out  1          high when the FSM is not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, rr pointer=0; req_ready=0, out_valid=0, out_id/out_s/out_e/out_f=0, busy=0.
//  FSM states: IDLE -> CONV -> DONE -> IDLE.
//  IDLE
//   - req_ready is combinational: one-hot on the first valid requester at or after the rr pointer (wrapping).
//   - On accept: latch sample and ID, set rr pointer = granted+1 mod NREQ, go to CONV.
//   - req_ready=0 in every other state.
//  CONV: convert the latched operand, register S/E/F into the out_* regs, set out_valid=1, go to DONE.
//  DONE
//   - out_* held stable while out_valid & ~out_ready.
//   - On out_ready: clear out_valid, go to IDLE.
//   - Re-acceptance of a new sample therefore happens no earlier than the cycle after the handoff.
//  Latency and throughput
//   - out_valid rises 2 clocks after the accept edge.
//   - Minimum 3 cycles per sample, with no result bypass.
//  Conversion rules (sub-module)
//   - S = D[11]; magnitude M = |D|.
//   - lz = leading zeros of M within bits [11:4]; E = 8 - lz, then clamp to 7 if 8.
//   - F = 4 bits of M starting at the leading one.
//   - Round half-up on the next bit below F.
//   - Rounding F overflow (1111 + 1): F=1000, E=E+1.
//   - If E would exceed 7: saturate to E=7, F=1111.
//   - M < 16: E=0, F=M[3:0], no rounding.
//   - D=0x800 (-2048): S=1, E=7, F=1111.
//  Boundaries
//   - Requesters not granted simply wait; nothing is dropped.
//   - A requester may deassert req_valid at any time before it is granted.
//   - A lone requester gets back-to-back grants.
//   - Reset asserted mid-CONV or mid-DONE discards the operand and the pending result; out_valid falls on the next edge.
// CONFIGURATION
//  FCS_STATS_EN defined:
//   - Adds outputs stat_conv (16) and stat_sat (16), both reset to 0.
//   - stat_conv increments on each accept.
//   - stat_sat increments on each result that saturated, including -2048.
//   - Both counters wrap at 0xFFFF.
//  FCS_STATS_EN undefined: the ports and counters are absent.
// STRUCTURE
//  Shared package fcs_pkg:
//   - FSM state enum {IDLE, CONV, DONE}.
//   - Constants DW=12, EW=3, FW=4, E_MAX=3'd7, F_MAX=4'hF.
//  Sub-module fcs_core: purely combinational 12-bit -> {S,E,F,sat}, instantiated once.
//  Top level holds the arbiter, FSM, operand/result registers and optional counters.
// TESTING
//  1. Single sample: req0 D=0x1A6 -> accepted, out_valid 2 clocks later, id=0 S=0 E=5 F=1101; 0xE5A (-422) -> S=1 E=5 F=1101.
//  2. Rounding: D=0x3E0 -> E=7 F=1000; D=0x7FF -> E=7 F=1111 (saturated); D=0x800 -> S=1 E=7 F=1111; D=0x000 -> E=0 F=0; D=0x00B -> E=0 F=1011.
//  3. Fairness: NREQ=2, both valid continuously -> grants alternate 0,1,0,1 across 8 results, none starved.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_* stable, req_ready stays 0; out_ready=1 -> handoff, next accept the following cycle.
//  5. Reset mid-op: assert rst in CONV -> next edge all outputs 0 and FSM=IDLE; the subsequent sample converts correctly.
//  6. FCS_STATS_EN: 10 samples, of which 3 saturate -> stat_conv=10, stat_sat=3; rst clears both.

Source files
------------

// File: rtl/fcs_pkg.sv
// Shared types and constants for the float_conv_sched slice.
// Holds the FSM state enum, the converter result payload and the format widths.
package fcs_pkg;

  localparam int unsigned DW = 12;  // input sample width
  localparam int unsigned EW = 3;   // exponent width
  localparam int unsigned FW = 4;   // mantissa width

  localparam logic [EW-1:0] E_MAX = 3'd7;
  localparam logic [FW-1:0] F_MAX = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } fcs_state_e;

  // Converter output: sign, exponent, mantissa and a saturation flag.
  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [FW-1:0] f;
    logic          sat;
  } fcs_result_t;

endpackage

// File: rtl/float_conv_sched_core.sv
// fcs_core: combinational 12-bit two's-complement -> S/E/F converter.
// Ports:
//   d   in  DW            two's-complement sample
//   res out fcs_result_t  {s, e, f, sat}
module fcs_core
  import fcs_pkg::*;
(
  input  logic [DW-1:0] d,
  output fcs_result_t   res
);

  logic [DW-1:0] mag;
  logic [3:0]    lead;
  logic          found;
  logic [4:0]    top5;
  logic [FW:0]   f_rnd;
  logic [EW:0]   e_ext;

  // Normalise, round half-up on the bit below F, then saturate.
  always_comb begin
    mag   = d[DW-1] ? DW'(~d + DW'(1)) : d;
    lead  = '0;
    found = 1'b0;
    // Highest set bit within [11:4]; later iterations win.
    for (int i = 4; i < int'(DW); i++) begin
      if (mag[i]) begin
        lead  = 4'(i);
        found = 1'b1;
      end
    end
    // Leading one plus three bits of F, then the rounding bit.
    top5  = 5'(mag >> (lead - 4'd4));
    f_rnd = {1'b0, top5[4:1]} + 5'(top5[0]);
    e_ext = 4'(lead - 4'd3);

    res.s   = d[DW-1];
    res.sat = 1'b0;
    res.e   = '0;
    res.f   = mag[FW-1:0];

    if (found) begin
      if (f_rnd[FW]) begin
        res.f = 4'b1000;
        e_ext = e_ext + 4'd1;
      end else begin
        res.f = f_rnd[FW-1:0];
      end
      // Exponent 8 or more (including |-2048|) saturates.
      if (e_ext[EW]) begin
        res.e   = E_MAX;
        res.f   = F_MAX;
        res.sat = 1'b1;
      end else begin
        res.e = e_ext[EW-1:0];
      end
    end
  end

endmodule

// File: rtl/float_conv_sched.sv
// float_conv_sched: round-robin scheduler sharing one 12-bit -> S/E/F converter
// among NREQ requesters. One sample per grant, result held until consumed.
// Optional macro FCS_STATS_EN adds stat_conv / stat_sat counters.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_data   per-requester sample handshake (slice i = [12*i+11:12*i])
//   req_ready            one-hot accept strobe (combinational, IDLE only)
//   out_valid/out_ready  result handshake
//   out_id,out_s,out_e,out_f  tagged result
//   busy                 FSM not in IDLE
//   stat_conv, stat_sat  accept / saturation counters (FCS_STATS_EN only)
module float_conv_sched
  import fcs_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDW-1:0]       out_id,
  output logic                 out_s,
  output logic [EW-1:0]        out_e,
  output logic [FW-1:0]        out_f,
  output logic                 busy
`ifdef FCS_STATS_EN
  ,
  output logic [15:0]          stat_conv,
  output logic [15:0]          stat_sat
`endif
);

  fcs_state_e     state;
  logic [IDW-1:0] rr;
  logic [DW-1:0]  op;
  logic [IDW-1:0] op_id;

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_id;
  logic [DW-1:0]   gnt_data;
  logic            gnt_any;
  logic [IDW-1:0]  rr_next;
  fcs_result_t     res;

  // Round-robin pick: pass 0 scans requesters at/after rr, pass 1 wraps below rr.
  always_comb begin
    gnt_oh   = '0;
    gnt_id   = '0;
    gnt_data = '0;
    gnt_any  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!gnt_any && req_valid[i] && ((IDW'(i) >= rr) == (p == 0))) begin
          gnt_any   = 1'b1;
          gnt_oh[i] = 1'b1;
          gnt_id    = IDW'(i);
          gnt_data  = req_data[DW*i +: DW];
        end
      end
    end
  end

  assign rr_next   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
  assign req_ready = (state == IDLE) ? gnt_oh : '0;

  fcs_core u_core (
    .d   (op),
    .res (res)
  );

  // Control FSM with operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      op        <= '0;
      op_id     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            op    <= gnt_data;
            op_id <= gnt_id;
            rr    <= rr_next;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          out_id    <= op_id;
          out_s     <= res.s;
          out_e     <= res.e;
          out_f     <= res.f;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef FCS_STATS_EN
  // Free-running wrap-around counters of accepts and saturated results.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conv <= '0;
      stat_sat  <= '0;
    end else begin
      if (state == IDLE && gnt_any) stat_conv <= stat_conv + 16'd1;
      if (state == CONV && res.sat) stat_sat  <= stat_sat + 16'd1;
    end
  end
`else
  logic sat_unused;
  assign sat_unused = res.sat;
`endif

endmodule
